// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter bundle for uart_tx_arbiter.
// The slave modport is the arbiter view; master is the requester/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   byte_valid;
    logic [8*NUM_REQ-1:0] byte_data;
    logic [NUM_REQ-1:0]   byte_last;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   byte_ack;
    logic                 tx_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;

    modport slave (
        input  req, byte_valid, byte_data, byte_last, tx_ready,
        output grant, byte_ack, tx_start, tx_data
    );

    modport master (
        output req, byte_valid, byte_data, byte_last, tx_ready,
        input  grant, byte_ack, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between
// NUM_REQ byte-stream requesters. Owns the slow tx_ready/tx_start handshake so
// requesters only see a one-cycle byte_ack per latched byte.
// Optional build macro ARB_TIMEOUT_EN adds an idle-grant watchdog (TIMEOUT cycles).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no owner; pick next requester from rr_ptr upward
// S_GRANT   | owner holds transmitter; waiting for a byte (or abort)
// S_WAIT_ACC| tx_start held until transmitter drops tx_ready
// S_WAIT_DONE| transmitter busy; wait for tx_ready before next byte/release
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ),
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_ACC,
        S_WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] byte_ack_q, byte_ack_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               last_q, last_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;

    logic [PTR_W-1:0]   pick;
    logic               pick_vld;
    logic [PTR_W-1:0]   nxt_ptr;
    logic               rel_now;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
`endif

    // Round-robin search: first set req at offset 0..NUM_REQ-1 from rr_ptr, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req[idx]) begin
                pick     = PTR_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign nxt_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

    // Next-state and output decode; every exit from ownership funnels through rel_now.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        last_d     = last_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        byte_ack_d = '0;
        rel_now    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    state_d       = S_GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
            end
            S_GRANT: begin
                // A valid byte wins over a simultaneous req drop; abort is seen next visit.
                if (bus.byte_valid[owner_q] && bus.tx_ready) begin
                    tx_data_d           = bus.byte_data[{owner_q, 3'b000} +: 8];
                    last_d              = bus.byte_last[owner_q];
                    tx_start_d          = 1'b1;
                    byte_ack_d[owner_q] = 1'b1;
                    state_d             = S_WAIT_ACC;
`ifdef ARB_TIMEOUT_EN
                    cnt_d               = '0;
`endif
                end else if (!bus.req[owner_q]) begin
                    rel_now = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rel_now   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_WAIT_ACC: begin
                // Transmitter samples start on its slow clock, so no cycle limit here.
                if (!bus.tx_ready) begin
                    tx_start_d = 1'b0;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_ready) begin
                    if (last_q) begin
                        rel_now = 1'b1;
                    end else begin
                        state_d = S_GRANT;
`ifdef ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rel_now) begin
            grant_d  = '0;
            rr_ptr_d = nxt_ptr;
            state_d  = S_IDLE;
        end
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            byte_ack_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            byte_ack_q <= byte_ack_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.grant    = grant_q;
    assign bus.byte_ack = byte_ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign busy         = (state_q != S_IDLE);
`ifdef ARB_TIMEOUT_EN
    assign timeout      = timeout_q;
`else
    assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with three requesters (non-power-of-2 wrap).
// Expected bytes come from a packet-level round-robin model; a monitor pops them
// as the transmitter model accepts bytes.
module tb_uart_tx_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic timeout;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [9:0] exp_q[$];
    logic [8:0] pkt_data [N][256];
    int         pkt_pos [N] = '{default: 0};
    int         pkt_end [N] = '{default: 0};
    int         ack_cnt [N] = '{default: 0};
    int         acc_cnt = 0;
    int         rlen [N];
    int         rbase [N];
    int         model_ptr = 0;
    int         xm_hold = 0;
    int         xm_bmin = 1;
    int         xm_bmax = 6;
    logic       manual = 1'b0;
    logic [N-1:0] man_req = '0;
    logic [N-1:0] man_valid = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Requester side: each requester streams its queued bytes, popping on byte_ack.
    initial begin
        bus.req        = '0;
        bus.byte_valid = '0;
        bus.byte_data  = '0;
        bus.byte_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (!manual && bus.byte_ack[i] === 1'b1 && pkt_pos[i] < pkt_end[i])
                    pkt_pos[i]++;
            for (int i = 0; i < N; i++) begin
                logic have;
                have = (pkt_pos[i] < pkt_end[i]);
                if (manual) begin
                    bus.req[i]        = man_req[i];
                    bus.byte_valid[i] = man_valid[i];
                end else begin
                    bus.req[i]        = have;
                    bus.byte_valid[i] = have && ($urandom_range(3, 0) != 0);
                end
                bus.byte_data[8*i +: 8] = pkt_data[i][pkt_pos[i] & 255][7:0];
                bus.byte_last[i]        = pkt_data[i][pkt_pos[i] & 255][8];
            end
        end
    end

    // Transmitter model: accept after xm_hold cycles of tx_start, then stay busy a while.
    initial begin
        int st = 0;
        int hold_left = 0;
        int busy_left = 0;
        logic first_busy = 1'b0;
        logic [7:0] held = '0;
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (st == 1) begin
                if (first_busy) begin
                    chk("tx_start_cleared", bus.tx_start, 1'b0);
                    first_busy = 1'b0;
                end
                if (busy_left <= 0) begin
                    bus.tx_ready = 1'b1;
                    st = 0;
                end else begin
                    busy_left--;
                end
            end else if (st == 2) begin
                chk("tx_start_held", bus.tx_start, 1'b1);
                chk("tx_data_stable", bus.tx_data, held);
                hold_left--;
            end else if (bus.tx_start === 1'b1) begin
                held = bus.tx_data;
                hold_left = xm_hold;
                st = 2;
            end
            if (st == 2 && hold_left <= 0) begin
                bus.tx_ready = 1'b0;
                busy_left = $urandom_range(xm_bmax, xm_bmin);
                first_busy = 1'b1;
                st = 1;
            end
        end
    end

    // Monitor: scoreboard pop on each accepted byte; ack must belong to the owner.
    initial begin
        logic seen = 1'b0;
        logic [9:0] e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (bus.byte_ack !== '0) begin
                    chk("ack_is_owner", bus.byte_ack, bus.grant);
                    for (int i = 0; i < N; i++) if (bus.byte_ack[i] === 1'b1) ack_cnt[i]++;
                end
                if (bus.tx_start === 1'b1 && bus.tx_ready === 1'b0 && !seen) begin
                    seen = 1'b1;
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got %02h, expected none", bus.tx_data);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = '0;
                        oh[e[9:8]] = 1'b1;
                        chk("tx_owner", bus.grant, oh);
                        chk("tx_data", bus.tx_data, e[7:0]);
                    end
                end
                if (bus.tx_start !== 1'b1) seen = 1'b0;
            end
        end
    end

    // Load one packet per requester in mask and queue the expected transmit order.
    task automatic run_round(input logic [N-1:0] mask);
        int start [N];
        logic [N-1:0] pend;
        int id;
        logic [7:0] d;
        pend = mask;
        for (int i = 0; i < N; i++) begin
            start[i] = pkt_end[i];
            if (mask[i]) begin
                for (int k = 0; k < rlen[i]; k++) begin
                    d = (rbase[i] >= 0) ? 8'(rbase[i] + k) : 8'($urandom);
                    pkt_data[i][(start[i] + k) & 255] = {(k == rlen[i] - 1), d};
                end
                pkt_end[i] = pkt_end[i] + rlen[i];
            end
        end
        while (pend != '0) begin
            id = 0;
            for (int k = N - 1; k >= 0; k--) begin
                int c;
                c = (model_ptr + k) % N;
                if (pend[c]) id = c;
            end
            for (int k = 0; k < rlen[id]; k++)
                exp_q.push_back({2'(id), pkt_data[id][(start[id] + k) & 255][7:0]});
            pend[id] = 1'b0;
            model_ptr = (id + 1) % N;
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            #1;
            done = (exp_q.size() == 0) && (busy === 1'b0) && (bus.tx_ready === 1'b1);
            for (int i = 0; i < N; i++) if (pkt_pos[i] != pkt_end[i]) done = 1'b0;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s: drain timed out, %0d bytes outstanding", nm, exp_q.size());
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_grant"},    bus.grant,    '0);
        chk({nm, "_byte_ack"}, bus.byte_ack, '0);
        chk({nm, "_tx_start"}, bus.tx_start, 1'b0);
        chk({nm, "_tx_data"},  bus.tx_data,  8'h00);
        chk({nm, "_busy"},     busy,         1'b0);
        chk({nm, "_timeout"},  timeout,      1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ack0;
        logic started;
        for (int i = 0; i < N; i++) begin
            rlen[i]  = 1;
            rbase[i] = -1;
        end

        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single 3-byte packet, 10-cycle transmitter busy time.
        xm_bmin = 10; xm_bmax = 10;
        rlen[0] = 3; rbase[0] = 8'h41;
        base = ack_cnt[0];
        @(posedge clk); #1;
        run_round(3'b001);
        @(negedge clk); #1;
        chk("grant_before_latency", bus.grant, 3'b000);
        @(negedge clk); #1;
        chk("grant_latency", bus.grant, 3'b001);
        wait_drain(2000, "single_pkt");
        chk("single_ack_count", ack_cnt[0] - base, 3);
        chk("single_grant_release", bus.grant, 3'b000);

        // One-byte packet (last on first byte); rr_ptr moves to 1.
        xm_bmin = 1; xm_bmax = 6;
        rlen[0] = 1; rbase[0] = 8'h5A;
        @(posedge clk); #1;
        run_round(3'b001);
        wait_drain(2000, "one_byte");

        // tx_ready stays high for 20 cycles after tx_start.
        xm_hold = 20; xm_bmin = 2; xm_bmax = 4;
        rlen[1] = 2; rbase[1] = 8'hB0;
        @(posedge clk); #1;
        run_round(3'b010);
        wait_drain(2000, "hold");
        xm_hold = 0;

        // All requesters at once: service order starts at rr_ptr.
        for (int i = 0; i < N; i++) begin rlen[i] = 2; rbase[i] = -1; end
        @(posedge clk); #1;
        run_round(3'b111);
        wait_drain(2000, "all_req");

        // Abort: owner drops req before any byte; pointer moves past it.
        @(posedge clk); #1;
        manual = 1'b1; man_req = 3'b010; man_valid = '0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("abort_grant", bus.grant, 3'b010);
        man_req = 3'b101;
        @(negedge clk);
        @(negedge clk); #1;
        chk("abort_release", bus.grant, 3'b000);
        chk("abort_no_start", bus.tx_start, 1'b0);
        @(negedge clk); #1;
        chk("abort_next_owner", bus.grant, 3'b100);
        man_req = '0;
        repeat (3) @(negedge clk);
        model_ptr = 0;

`ifdef ARB_TIMEOUT_EN
        // Stalled owner is released after 16 GRANT cycles.
        #1;
        man_req = 3'b011;
        @(negedge clk);
        @(negedge clk); #1;
        chk("to_grant", bus.grant, 3'b001);
        for (int c = 1; c < 16; c++) begin
            @(negedge clk); #1;
            chk("to_early", timeout, 1'b0);
        end
        @(negedge clk); #1;
        chk("to_pulse", timeout, 1'b1);
        chk("to_release", bus.grant, 3'b000);
        @(negedge clk); #1;
        chk("to_pulse_end", timeout, 1'b0);
        chk("to_next_owner", bus.grant, 3'b010);
        man_req = '0;
        repeat (3) @(negedge clk);
        model_ptr = 2;
`endif
        manual = 1'b0;

        // Randomized rounds.
        for (int r = 0; r < 25; r++) begin
            xm_hold = $urandom_range(3, 0);
            xm_bmin = 1; xm_bmax = 6;
            for (int i = 0; i < N; i++) begin
                rlen[i]  = $urandom_range(4, 1);
                rbase[i] = -1;
            end
            @(posedge clk); #1;
            run_round(3'($urandom_range(7, 1)));
            wait_drain(2000, "random_round");
        end
        xm_hold = 0;

        // Put rr_ptr at 1 so a missing pointer reset is visible later.
        rlen[0] = 1; rbase[0] = -1;
        @(posedge clk); #1;
        run_round(3'b001);
        wait_drain(2000, "pre_reset");

        // Reset during WAIT_DONE of byte 2 of 4.
        xm_bmin = 8; xm_bmax = 8;
        rlen[0] = 4;
        base = acc_cnt;
        @(posedge clk); #1;
        run_round(3'b001);
        for (int c = 0; c < 500 && acc_cnt < base + 2; c++) begin
            @(negedge clk); #1;
        end
        chk("reset_setup_reached", (acc_cnt >= base + 2), 1'b1);
        manual = 1'b1; man_req = '0; man_valid = '0;
        ack0 = ack_cnt[0];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals("midpkt_reset");
        exp_q.delete();
        for (int i = 0; i < N; i++) pkt_end[i] = pkt_pos[i];
        model_ptr = 0;
        started = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (bus.tx_start === 1'b1) started = 1'b1;
        end
        chk("post_reset_no_start", started, 1'b0);
        chk("post_reset_no_ack", ack_cnt[0], ack0);
        manual = 1'b0;
        xm_bmin = 1; xm_bmax = 6;
        for (int i = 0; i < N; i++) begin rlen[i] = 2; rbase[i] = -1; end
        @(posedge clk); #1;
        run_round(3'b111);
        wait_drain(2000, "post_reset_round");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
